key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1_000_000, stable-level cycles required to accept a press or release (20 ms at 50 MHz).
REQ-002 Parameter LONG_CYC, default 50_000_000, held cycles after accepted press before long-press report (1 s at 50 MHz).
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 key_in  input  1  raw mechanical key, active-low, asynchronous to clk, bouncing.
REQ-007 key_clean_n  output  1  debounced key level, active-low, registered (drop-in for the display-enable stage's key input).
REQ-008 key_press  output  1  one-cycle pulse on accepted press.
REQ-009 key_release  output  1  one-cycle pulse on accepted release.
REQ-010 key_long  output  1  one-cycle pulse, at most once per press, when held LONG_CYC cycles.

Function
REQ-011 key_in SHALL pass through a two-flop synchronizer; only the second flop output (ks) drives the FSM.
REQ-012 FSM states SHALL be IDLE, PRESS_CHK, HELD, RELEASE_CHK.
REQ-013 IDLE: ks=0 -> PRESS_CHK, deb_cnt<=0; otherwise remain.
REQ-014 PRESS_CHK: ks=1 -> IDLE (bounce rejected, no output); ks=0 and deb_cnt=DEBOUNCE_CYC-1 -> HELD, key_press<=1, key_clean_n<=0, long_cnt<=0; else deb_cnt+1.
REQ-015 HELD: ks=1 -> RELEASE_CHK, deb_cnt<=0; long_cnt increments saturating at LONG_CYC-1; key_long<=1 on the cycle long_cnt reaches LONG_CYC-1, flag long_done set to block repeat.
REQ-016 RELEASE_CHK: ks=0 -> HELD (bounce rejected, long_cnt and long_done preserved); ks=1 and deb_cnt=DEBOUNCE_CYC-1 -> IDLE, key_release<=1, key_clean_n<=1, long_done<=0; else deb_cnt+1.
REQ-017 long_cnt SHALL keep counting in RELEASE_CHK; a long event reached there SHALL still pulse key_long.
REQ-018 Latency: with edge N the first edge sampling key_in low and key_in held low, key_press and key_clean_n=0 SHALL appear after edge N+DEBOUNCE_CYC+2; release symmetric.
REQ-019 Pulse outputs SHALL be high exactly one cycle and default low every other cycle; key_press and key_release never coincide.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter, minimum 1; no wrap-around, counters never exceed parameter-1.
REQ-021 Glitches shorter than DEBOUNCE_CYC cycles at ks SHALL produce no output change.
REQ-022 key_long and key_press may not coincide; if LONG_CYC < 1 behaviour is unsupported (parameter check in elaboration).

Reset
REQ-023 On rst_n=0, asynchronously: sync flops<=1, state<=IDLE, deb_cnt<=0, long_cnt<=0, long_done<=0, key_clean_n<=1, key_press/key_release/key_long<=0.
REQ-024 Reset mid-press SHALL discard the press with no release pulse; after reset deassertion a still-low key SHALL be debounced afresh as a new press.

Structure
REQ-025 Shared package SHALL hold FSM state encoding and default timing constants (CLK_HZ, DEBOUNCE_MS, LONG_MS derived cycle counts).
REQ-026 Synchronizer SHALL be sub-module key_sync (2 flops, reset value parameter, default 1).

Verification (bench overrides DEBOUNCE_CYC=8, LONG_CYC=32)
REQ-027 key_in low from edge 10, held -> key_press one-cycle high after edge 20, key_clean_n=0 from same cycle.
REQ-028 key_in low pulses of 3 cycles every 5 cycles for 40 cycles -> no key_press, key_clean_n stays 1.
REQ-029 press held 60 cycles after key_press -> exactly one key_long, 32 cycles after key_press edge; no repeat.
REQ-030 after accepted press, key_in high 4 cycles then low 2 then high held -> single key_release 8+2 cycles after final rise, key_clean_n=1.
REQ-031 rst_n pulsed low during HELD -> outputs at reset values immediately, no key_release; key still low -> new key_press 10 cycles after rst_n release.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared FSM encoding and default timing for the key debouncer.
// Default cycle counts are derived from the board clock and the millisecond targets.
package key_debounce_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int LONG_MS     = 1000;

  localparam int DEF_DEBOUNCE_CYC = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEF_LONG_CYC     = (CLK_HZ / 1000) * LONG_MS;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_t;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous level input.
// RST_VAL sets the idle level both flops return to on reset.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for an active-low mechanical key: clean level plus press, release
// and one-shot long-press pulses, all registered.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_clean_n,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DEB_W  = cnt_w(DEBOUNCE_CYC);
  localparam int LONG_W = cnt_w(LONG_CYC);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC - 1);

  if (LONG_CYC < 1 || DEBOUNCE_CYC < 1) begin : g_param_chk
    $error("key_debounce: DEBOUNCE_CYC and LONG_CYC must be >= 1");
  end

  logic              w_ks;
  state_t            r_state,    w_state;
  logic [DEB_W-1:0]  r_deb_cnt,  w_deb_cnt;
  logic [LONG_W-1:0] r_long_cnt, w_long_cnt;
  logic              r_long_done, w_long_done;
  logic              r_clean_n,  w_clean_n;
  logic              r_press,    w_press;
  logic              r_release,  w_release;
  logic              r_long,     w_long;

  key_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (key_in),
    .o_q   (w_ks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_deb_cnt   <= '0;
      r_long_cnt  <= '0;
      r_long_done <= 1'b0;
      r_clean_n   <= 1'b1;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_deb_cnt   <= w_deb_cnt;
      r_long_cnt  <= w_long_cnt;
      r_long_done <= w_long_done;
      r_clean_n   <= w_clean_n;
      r_press     <= w_press;
      r_release   <= w_release;
      r_long      <= w_long;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_deb_cnt   = r_deb_cnt;
    w_long_cnt  = r_long_cnt;
    w_long_done = r_long_done;
    w_clean_n   = r_clean_n;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;

    // Hold time keeps running through release bounces, so a long press that
    // matures while the release is still being qualified is still reported.
    if (r_state == ST_HELD || r_state == ST_RELEASE_CHK) begin
      if (r_long_cnt == LONG_MAX) begin
        if (!r_long_done) begin
          w_long      = 1'b1;
          w_long_done = 1'b1;
        end
      end else begin
        w_long_cnt = r_long_cnt + 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (!w_ks) begin
          w_state   = ST_PRESS_CHK;
          w_deb_cnt = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (w_ks) begin
          w_state = ST_IDLE;
        end else if (r_deb_cnt == DEB_MAX) begin
          w_state    = ST_HELD;
          w_press    = 1'b1;
          w_clean_n  = 1'b0;
          w_long_cnt = '0;
        end else begin
          w_deb_cnt = r_deb_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (w_ks) begin
          w_state   = ST_RELEASE_CHK;
          w_deb_cnt = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (!w_ks) begin
          w_state = ST_HELD;
        end else if (r_deb_cnt == DEB_MAX) begin
          w_state     = ST_IDLE;
          w_release   = 1'b1;
          w_clean_n   = 1'b1;
          w_long_done = 1'b0;
        end else begin
          w_deb_cnt = r_deb_cnt + 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign key_clean_n = r_clean_n;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYC=8, LONG_CYC=32.
// Expected pulses are queued with their edge number; a negedge monitor pops them.
module tb_key_debounce;

  localparam int DEB = 8;
  localparam int LNG = 32;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_clean_n, key_press, key_release, key_long;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];

  key_debounce #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LNG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_clean_n (key_clean_n),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc at a negedge equals the number of the rising edge that just produced the outputs
  always @(negedge clk) begin
    logic [2:0] p;
    ev_t e;
    p = {key_long, key_release, key_press};
    for (int k = 0; k < 3; k++) begin
      if (p[k]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL evt_unexpected kind=%0d at edge %0d, want no event", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.cyc !== cyc) begin
            bad++;
            $display("FAIL evt_order got kind=%0d edge=%0d want kind=%0d edge=%0d",
                     k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL reset_clean_n got=%b want=1", key_clean_n); end
    total++; if (key_press   !== 1'b0) begin bad++; $display("FAIL reset_press got=%b want=0", key_press); end
    total++; if (key_release !== 1'b0) begin bad++; $display("FAIL reset_release got=%b want=0", key_release); end
    total++; if (key_long    !== 1'b0) begin bad++; $display("FAIL reset_long got=%b want=0", key_long); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_press_long_release();
    int n, r;
    @(negedge clk);
    key_in = 1'b0;
    n = cyc + 1;
    exp_q.push_back('{kind: K_PRESS, cyc: n + DEB + 2});
    exp_q.push_back('{kind: K_LONG,  cyc: n + DEB + 2 + LNG});
    repeat (10) @(negedge clk);
    total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL press_early_clean got=%b want=1", key_clean_n); end
    @(negedge clk);
    total++; if (key_clean_n !== 1'b0) begin bad++; $display("FAIL press_clean got=%b want=0", key_clean_n); end
    repeat (60) @(negedge clk);
    #1;
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL press_long_pending got=%0d want=0", exp_q.size()); end
    // release with a bounce: high 4, low 2, then high held
    @(negedge clk);
    key_in = 1'b1;
    repeat (4) @(negedge clk);
    key_in = 1'b0;
    repeat (2) @(negedge clk);
    key_in = 1'b1;
    r = cyc + 1;
    exp_q.push_back('{kind: K_REL, cyc: r + DEB + 2});
    repeat (5) @(negedge clk);
    total++; if (key_clean_n !== 1'b0) begin bad++; $display("FAIL release_early_clean got=%b want=0", key_clean_n); end
    repeat (7) @(negedge clk);
    #1;
    total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL release_clean got=%b want=1", key_clean_n); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL release_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    int n, r;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      key_in = 1'b0;
      repeat (3) @(negedge clk);
      key_in = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL glitch_clean[%0d] got=%b want=1", i, key_clean_n); end
    end
    repeat (6) @(negedge clk);
    // 8 low samples is one short of acceptance
    key_in = 1'b0;
    repeat (8) @(negedge clk);
    key_in = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL glitch_edge_clean got=%b want=1", key_clean_n); end
    // 9 low samples is just enough
    @(negedge clk);
    key_in = 1'b0;
    n = cyc + 1;
    exp_q.push_back('{kind: K_PRESS, cyc: n + DEB + 2});
    repeat (9) @(negedge clk);
    key_in = 1'b1;
    r = cyc + 1;
    exp_q.push_back('{kind: K_REL, cyc: r + DEB + 2});
    repeat (22) @(negedge clk);
    #1;
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL glitch_min_press_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_press();
    int n, c, r;
    @(negedge clk);
    key_in = 1'b0;
    n = cyc + 1;
    exp_q.push_back('{kind: K_PRESS, cyc: n + DEB + 2});
    repeat (15) @(negedge clk);
    total++; if (key_clean_n !== 1'b0) begin bad++; $display("FAIL midrst_held_clean got=%b want=0", key_clean_n); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL midrst_async_clean got=%b want=1", key_clean_n); end
    total++; if (key_release !== 1'b0) begin bad++; $display("FAIL midrst_release got=%b want=0", key_release); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    exp_q.push_back('{kind: K_PRESS, cyc: c + 1 + DEB + 2});
    repeat (10) @(negedge clk);
    total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL midrst_reacq_early got=%b want=1", key_clean_n); end
    repeat (2) @(negedge clk);
    #1;
    total++; if (key_clean_n !== 1'b0) begin bad++; $display("FAIL midrst_reacq_clean got=%b want=0", key_clean_n); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL midrst_pending got=%0d want=0", exp_q.size()); end
    @(negedge clk);
    key_in = 1'b1;
    r = cyc + 1;
    exp_q.push_back('{kind: K_REL, cyc: r + DEB + 2});
    repeat (12) @(negedge clk);
    #1;
    total++; if (key_clean_n !== 1'b1) begin bad++; $display("FAIL midrst_final_clean got=%b want=1", key_clean_n); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL midrst_final_pending got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_press_long_release();
    test_glitch();
    test_reset_mid_press();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
